// File: rtl/updi_tx.sv
// UPDI transmitter: fetches bytes from an upstream FIFO and serialises each one
// as a 12-bit frame (start, 8 data LSB first, even parity, 2 stop bits).
module updi_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       idx_q, idx_n;
  logic             stop_q, stop_n;
  logic [7:0]       shreg_q, shreg_n;
  logic             parity_q, parity_n;
  logic             bit_end;

  logic             tx_n;
  logic             tx_en_n;
  logic             rd_n;
  logic             busy_n;
  logic             done_n;

  assign bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      tx_en      <= 1'b0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      idx_q      <= idx_n;
      stop_q     <= stop_n;
      shreg_q    <= shreg_n;
      parity_q   <= parity_n;
      tx         <= tx_n;
      tx_en      <= tx_en_n;
      fifo_rd_en <= rd_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Next-state, bit timing and registered-output precompute
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    stop_n   = stop_q;
    shreg_n  = shreg_q;
    parity_n = parity_q;

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (enable && !fifo_empty) begin
          state_n = FETCH;
        end
      end

      FETCH: begin
        state_n = LOAD;
      end

      // FIFO output register holds the fetched byte during this cycle
      LOAD: begin
        shreg_n  = fifo_data;
        parity_n = ^fifo_data;
        cnt_n    = '0;
        idx_n    = '0;
        stop_n   = 1'b0;
        state_n  = START;
      end

      START, DATA, PARITY, STOP: begin
        if (bit_end) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end

        if (bit_end) begin
          case (state_q)
            START: state_n = DATA;
            DATA: begin
              idx_n = idx_q + 3'd1;
              if (idx_q == 3'd7) begin
                state_n = PARITY;
              end
            end
            PARITY: state_n = STOP;
            default: begin
              if (stop_q) begin
                stop_n  = 1'b0;
                state_n = IDLE;
              end else begin
                stop_n = 1'b1;
              end
            end
          endcase
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it
  always_comb begin
    rd_n    = (state_n == FETCH);
    tx_en_n = (state_n inside {START, DATA, PARITY, STOP});
    busy_n  = (state_n != IDLE);
    done_n  = (state_q == STOP) && (state_n == IDLE);

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[idx_n];
      PARITY:  tx_n = parity_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_updi_tx.sv
// Self-checking bench for updi_tx: FIFO model, frame reference built from byte
// arithmetic, directed and random bytes, enable drop and mid-frame reset.
module tb_updi_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       tx;
  logic       tx_en;
  logic       busy;
  logic       frame_done;

  logic [7:0] mem [64];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  int         pushed = 0;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int rd_empty_errs = 0;

  always #5 clk = ~clk;

  updi_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .tx_en      (tx_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // FIFO with registered output: data appears the cycle after a read
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) rd_empty_errs <= rd_empty_errs + 1;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
    pushed++;
  endtask

  // Line levels in transmit order: index 0 is the start bit
  function automatic logic [11:0] frame_of(input logic [7:0] b);
    logic [11:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = ((ones % 2) == 1) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    f[11] = 1'b1;
    return f;
  endfunction

  task automatic run_frame(input logic [7:0] b, input int drop_at, output int gap);
    logic [11:0] exp_f;
    logic [11:0] obs_f;
    int waits;
    int en_cycles;
    logic unstable;
    logic idle_bad;
    exp_f = frame_of(b);
    obs_f = '0;
    waits = 0;
    unstable = 1'b0;
    idle_bad = 1'b0;
    en_cycles = 0;
    while (tx_en !== 1'b1 && waits < 400) begin
      if (tx !== 1'b1) idle_bad = 1'b1;
      @(negedge clk);
      waits++;
    end
    gap = waits + 1;
    chk("frame_start", tx_en, 1);
    chk("idle_tx_high", idle_bad, 0);
    for (int k = 0; k < 12 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at * int'(CPB)) enable = 1'b0;
      if (tx_en === 1'b1) en_cycles++;
      if (k % CPB == 0) obs_f[k / CPB] = tx;
      else if (tx !== obs_f[k / CPB]) unstable = 1'b1;
    end
    chk("frame_bits", obs_f, exp_f);
    chk("bit_hold", unstable, 0);
    chk("tx_en_len", en_cycles, 12 * CPB);
    @(negedge clk);
    chk("post_tx_en", tx_en, 0);
    chk("frame_done", frame_done, 1);
    chk("post_tx", tx, 1);
    @(negedge clk);
    chk("done_single", frame_done, 0);
  endtask

  initial begin
    int gap;
    int base;
    int done0;
    int waits;
    logic bad;
    logic [7:0] rb [16];
    logic [7:0] r1, r2, r3, r4;

    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with empty FIFO, then with data but disabled
    enable = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("idle_empty", bad, 0);
    enable = 1'b0;
    push(8'h55);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("idle_disabled", bad, 0);
    chk("no_reads", rd_cnt, 0);

    enable = 1'b1;
    run_frame(8'h55, -1, gap);
    chk("rd_one_55", rd_cnt, 1);

    push(8'h07); run_frame(8'h07, -1, gap);
    push(8'h00); run_frame(8'h00, -1, gap);
    push(8'hFF); run_frame(8'hFF, -1, gap);

    // Back-to-back pair
    base = rd_cnt;
    push(8'hA5);
    push(8'h3C);
    run_frame(8'hA5, -1, gap);
    run_frame(8'h3C, -1, gap);
    chk("b2b_gap", gap, 3);
    @(negedge clk);
    chk("b2b_reads", rd_cnt - base, 2);

    // Random back-to-back stream
    for (int i = 0; i < 16; i++) begin
      rb[i] = 8'($urandom);
      push(rb[i]);
    end
    for (int i = 0; i < 16; i++) begin
      run_frame(rb[i], -1, gap);
      if (i > 0) chk("rnd_gap", gap, 3);
    end

    // enable dropped during parity: frame finishes, no further fetch
    base = rd_cnt;
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    push(r1);
    push(r2);
    run_frame(r1, 9, gap);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    chk("drop_quiet", bad, 0);
    chk("drop_reads", rd_cnt - base, 1);
    enable = 1'b1;
    run_frame(r2, -1, gap);

    // Reset during DATA bit 3 abandons the frame
    done0 = done_cnt;
    r3 = 8'($urandom) & 8'hF7;
    push(r3);
    waits = 0;
    while (tx_en !== 1'b1 && waits < 400) begin
      @(negedge clk);
      waits++;
    end
    chk("rst_frame_start", tx_en, 1);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("pre_rst_tx_en", tx_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt, done0);
    chk("midrst_idle", tx_en, 0);
    r4 = 8'($urandom);
    push(r4);
    run_frame(r4, -1, gap);

    repeat (5) @(negedge clk);
    chk("rd_while_empty", rd_empty_errs, 0);
    chk("total_reads", rd_cnt, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updi_tx.md
UPDI_TX -- requirements
Module: updi_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set clock cycles per UPDI bit period (legal >= 2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 enable  input  1  high permits fetching new bytes.
REQ-005 fifo_data  input  8  byte from upstream FIFO output register, valid the cycle after a read.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_rd_en  output  1  registered read strobe to upstream FIFO, one cycle per byte.
REQ-008 tx  output  1  serial UPDI line data; idle level 1.
REQ-009 tx_en  output  1  line drive enable for the external tristate pad; high only while a frame is on the line.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_done  output  1  single-cycle pulse at frame completion.

Function
REQ-012 Frame format SHALL be 12 bits: start (0), 8 data bits LSB first, even parity bit (XOR of the 8 data bits), 2 stop bits (1).
REQ-013 Each bit SHALL hold tx constant for exactly CLKS_PER_BIT cycles, timed by an internal counter reset at each bit boundary.
REQ-014 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE -> FETCH on the edge where enable=1 and fifo_empty=0; fifo_rd_en SHALL be 1 for exactly the FETCH cycle.
REQ-016 FETCH -> LOAD unconditionally; fifo_rd_en returns to 0.
REQ-017 LOAD -> START; the shift register SHALL capture fifo_data on the edge that leaves LOAD, and parity SHALL be computed from that captured value.
REQ-018 START -> DATA after one bit period; DATA holds for 8 bit periods using a 3-bit index that wraps 7 -> 0 on exit; DATA -> PARITY -> STOP, one bit period each except STOP (two bit periods).
REQ-019 STOP -> IDLE at end of the second stop bit; frame_done SHALL pulse high the first IDLE cycle.
REQ-020 tx_en SHALL be 1 from the first START cycle through the last STOP cycle, else 0; tx SHALL be 1 whenever tx_en is 0.
REQ-021 Back-to-back: with the FIFO non-empty and enable=1, the next FETCH SHALL occur the cycle after frame_done (3-cycle idle gap between frames: IDLE, FETCH, LOAD).
REQ-022 enable deasserted mid-frame SHALL NOT abort the frame; only new fetches are suppressed.
REQ-023 fifo_empty rising after FETCH SHALL NOT affect the fetched byte.
REQ-024 At most one fifo_rd_en pulse SHALL be issued per frame; no read SHALL be issued while fifo_empty=1.

Reset
REQ-025 rst=1 SHALL immediately (without clock) force: state IDLE, tx=1, tx_en=0, fifo_rd_en=0, busy=0, frame_done=0, counters and shift register 0.
REQ-026 rst asserted mid-frame SHALL abandon the frame; the byte is lost and no frame_done is issued.
REQ-027 After rst release the block SHALL wait in IDLE until REQ-015 conditions hold.

Verification
REQ-028 CLKS_PER_BIT=4, FIFO holds 0x55, enable=1 -> one fifo_rd_en pulse; tx = 0,1,0,1,0,1,0,1,0,0,1,1 at 4 cycles each; tx_en high 48 cycles; frame_done pulse.
REQ-029 Byte 0x07 -> parity bit 1; byte 0x00 -> parity 0, data bits all 0; byte 0xFF -> parity 0.
REQ-030 FIFO holds 0xA5,0x3C -> two frames, exactly two fifo_rd_en pulses, 3 idle cycles with tx=1, tx_en=0 between them.
REQ-031 fifo_empty=1 or enable=0 for 100 cycles -> fifo_rd_en never asserts, tx=1, busy=0.
REQ-032 rst pulsed (between clock edges) during DATA bit 3 -> tx=1, tx_en=0 immediately; no frame_done; next byte transmits correctly afterwards.
REQ-033 enable dropped during PARITY -> frame completes with stop bits and frame_done; no further fetch.
